// File: rtl/salu_issue_sched.sv
// SALU issue scheduler: round-robin share of the scalar ALU between
// wavefront requesters, multiply sequencing and branch hold-off.
module salu_issue_sched #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_is_mul,
    input  logic [NUM_REQ-1:0] req_is_branch,
    input  logic               branch_done,
    input  logic [IDX_W-1:0]   branch_done_idx,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic               retire_valid,
    output logic [IDX_W-1:0]   retire_idx,
    output logic               salu_busy,
    output logic [NUM_REQ-1:0] br_pend
);

    typedef enum logic [0:0] {IDLE, MUL_WAIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         mul_cnt_q, mul_cnt_d;
    logic [IDX_W-1:0]   mul_idx_q, mul_idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               plain_q, plain_d;

    logic               issue_valid_d;
    logic [IDX_W-1:0]   issue_idx_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               retire_valid_d;
    logic [IDX_W-1:0]   retire_idx_d;
    logic               salu_busy_d;
    logic [NUM_REQ-1:0] br_pend_d;

    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               win_br, win_mul;
    logic               issue_ok, do_issue;
    logic               bd_hit, mul_fin;

    // grant holds last cycle's winner, masking a req that has not dropped yet
    assign elig = req & ~br_pend & ~grant;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_br   = req_is_branch[win_idx];
    assign win_mul  = req_is_mul[win_idx] & ~win_br;
    assign bd_hit   = branch_done & br_pend[branch_done_idx];
    assign mul_fin  = (state_q == MUL_WAIT) && (mul_cnt_q == 4'd0);
    // the multiply's final cycle may launch, as its retire frees the ALU
    assign issue_ok = !branch_done &&
                      !((state_q == MUL_WAIT) && (mul_cnt_q != 4'd0));
    assign do_issue = issue_ok & win_found;

    always_comb begin
        issue_valid_d  = do_issue;
        issue_idx_d    = do_issue ? win_idx : issue_idx;
        grant_d        = '0;
        plain_d        = do_issue & ~win_br & ~win_mul;
        rr_d           = rr_q;
        br_pend_d      = br_pend;
        retire_valid_d = 1'b0;
        retire_idx_d   = retire_idx;
        state_d        = state_q;
        mul_cnt_d      = mul_cnt_q;
        mul_idx_d      = mul_idx_q;
        salu_busy_d    = salu_busy;

        if (do_issue) begin
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            rr_d    = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
        end

        if (bd_hit)
            br_pend_d[branch_done_idx] = 1'b0;
        if (do_issue && win_br)
            br_pend_d[win_idx] = 1'b1;

        // branch owns the retire slot; a finishing multiply waits a cycle
        if (bd_hit) begin
            retire_valid_d = 1'b1;
            retire_idx_d   = branch_done_idx;
        end else if (mul_fin) begin
            retire_valid_d = 1'b1;
            retire_idx_d   = mul_idx_q;
        end else if (plain_q) begin
            retire_valid_d = 1'b1;
            retire_idx_d   = issue_idx;
        end

        unique case (state_q)
            IDLE: begin
                if (do_issue && win_mul) begin
                    state_d     = MUL_WAIT;
                    mul_cnt_d   = 4'(MUL_LAT - 1);
                    mul_idx_d   = win_idx;
                    salu_busy_d = 1'b1;
                end
            end
            MUL_WAIT: begin
                if (mul_cnt_q != 4'd0) begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end else if (!bd_hit) begin
                    state_d     = IDLE;
                    salu_busy_d = 1'b0;
                    if (do_issue && win_mul) begin
                        state_d     = MUL_WAIT;
                        mul_cnt_d   = 4'(MUL_LAT - 1);
                        mul_idx_d   = win_idx;
                        salu_busy_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_cnt_q    <= '0;
            mul_idx_q    <= '0;
            rr_q         <= '0;
            plain_q      <= 1'b0;
            issue_valid  <= 1'b0;
            issue_idx    <= '0;
            grant        <= '0;
            retire_valid <= 1'b0;
            retire_idx   <= '0;
            salu_busy    <= 1'b0;
            br_pend      <= '0;
        end else begin
            state_q      <= state_d;
            mul_cnt_q    <= mul_cnt_d;
            mul_idx_q    <= mul_idx_d;
            rr_q         <= rr_d;
            plain_q      <= plain_d;
            issue_valid  <= issue_valid_d;
            issue_idx    <= issue_idx_d;
            grant        <= grant_d;
            retire_valid <= retire_valid_d;
            retire_idx   <= retire_idx_d;
            salu_busy    <= salu_busy_d;
            br_pend      <= br_pend_d;
        end
    end

endmodule

// File: tb/tb_salu_issue_sched.sv
// Table-driven bench for salu_issue_sched with a retire-order scoreboard.
module tb_salu_issue_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] req_is_mul = '0;
    logic [7:0] req_is_branch = '0;
    logic       branch_done = 1'b0;
    logic [2:0] branch_done_idx = '0;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic [7:0] grant;
    logic       retire_valid;
    logic [2:0] retire_idx;
    logic       salu_busy;
    logic [7:0] br_pend;

    salu_issue_sched #(
        .NUM_REQ(8),
        .IDX_W  (3),
        .MUL_LAT(3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_is_mul     (req_is_mul),
        .req_is_branch  (req_is_branch),
        .branch_done    (branch_done),
        .branch_done_idx(branch_done_idx),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .grant          (grant),
        .retire_valid   (retire_valid),
        .retire_idx     (retire_idx),
        .salu_busy      (salu_busy),
        .br_pend        (br_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mul;
        logic [7:0] br;
        logic       bd;
        logic [2:0] bdi;
        logic       iv;
        logic [2:0] ii;
        logic       rv;
        logic [2:0] ri;
        logic       busy;
        logic [7:0] brp;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    task automatic row(input logic rst, input logic [7:0] rq,
                       input logic [7:0] ml, input logic [7:0] br,
                       input logic bd, input logic [2:0] bdi,
                       input logic iv, input logic [2:0] ii,
                       input logic rv, input logic [2:0] ri,
                       input logic busy, input logic [7:0] brp);
        vec_t v;
        v.rst = rst; v.req = rq; v.mul = ml; v.br = br;
        v.bd = bd; v.bdi = bdi; v.iv = iv; v.ii = ii;
        v.rv = rv; v.ri = ri; v.busy = busy; v.brp = brp;
        vecs.push_back(v);
    endtask

    task automatic rst_row();
        row(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_grant;
        logic [2:0] exp_ret;

        // A: two requesters alternate
        rst_row();
        row(0, 8'h05, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        row(0, 8'h05, 8'h00, 8'h00, 0, 0, 1, 2, 1, 0, 0, 8'h00);
        row(0, 8'h05, 8'h00, 8'h00, 0, 0, 1, 0, 1, 2, 0, 8'h00);
        row(0, 8'h05, 8'h00, 8'h00, 0, 0, 1, 2, 1, 0, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // B: all requesting, pointer sweeps and wraps
        rst_row();
        for (int i = 0; i < 10; i++)
            row(0, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 3'(i % 8),
                i != 0, 3'((i + 7) % 8), 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // C: multiply on 3, plain on 5 launches on the retire edge
        rst_row();
        row(0, 8'h28, 8'h08, 8'h00, 0, 0, 1, 3, 0, 0, 1, 8'h00);
        row(0, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        row(0, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        row(0, 8'h20, 8'h00, 8'h00, 0, 0, 1, 5, 1, 3, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 5, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // D: branch hold-off, resolve, stray branch_done
        rst_row();
        row(0, 8'h02, 8'h00, 8'h02, 0, 0, 1, 1, 0, 0, 0, 8'h02);
        row(0, 8'h02, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 0, 8'h02);
        row(0, 8'h02, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 0, 8'h02);
        row(0, 8'h02, 8'h00, 8'h02, 1, 1, 0, 0, 1, 1, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        row(0, 8'h04, 8'h00, 8'h00, 1, 6, 0, 0, 0, 0, 0, 8'h00);
        row(0, 8'h04, 8'h00, 8'h00, 0, 0, 1, 2, 0, 0, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2, 0, 8'h00);
        // E: branch resolves on the multiply's final cycle
        rst_row();
        row(0, 8'h01, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 0, 8'h01);
        row(0, 8'h02, 8'h02, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h01);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h01);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h01);
        row(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 0, 1, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // F: reset during multiply with a branch pending
        rst_row();
        row(0, 8'h10, 8'h00, 8'h10, 0, 0, 1, 4, 0, 0, 0, 8'h10);
        row(0, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h10);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h10);
        rst_row();
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        row(0, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // G: mul and branch flags together behave as a branch
        rst_row();
        row(0, 8'h40, 8'h40, 8'h40, 0, 0, 1, 6, 0, 0, 0, 8'h40);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h40);
        row(0, 8'h00, 8'h00, 8'h00, 1, 6, 0, 0, 1, 6, 0, 8'h00);
        row(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n           = ~vecs[i].rst;
            req             = vecs[i].req;
            req_is_mul      = vecs[i].mul;
            req_is_branch   = vecs[i].br;
            branch_done     = vecs[i].bd;
            branch_done_idx = vecs[i].bdi;
            if (vecs[i].rv)
                sb.push_back(vecs[i].ri);
            if (vecs[i].rst) begin
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            exp_grant = vecs[i].iv ? (8'h01 << vecs[i].ii) : 8'h00;
            chk($sformatf("row%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].iv));
            chk($sformatf("row%0d retire_valid", i), 32'(retire_valid), 32'(vecs[i].rv));
            chk($sformatf("row%0d salu_busy", i), 32'(salu_busy), 32'(vecs[i].busy));
            chk($sformatf("row%0d br_pend", i), 32'(br_pend), 32'(vecs[i].brp));
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(exp_grant));
            if (vecs[i].iv || vecs[i].rst)
                chk($sformatf("row%0d issue_idx", i), 32'(issue_idx), 32'(vecs[i].ii));
            if (vecs[i].rst)
                chk($sformatf("row%0d retire_idx", i), 32'(retire_idx), 32'(0));
            if (retire_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("row%0d unexpected retire", i), 32'(retire_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_ret = sb.pop_front();
                    chk($sformatf("row%0d sb retire_idx", i), 32'(retire_idx), 32'(exp_ret));
                end
            end
        end
        chk("scoreboard drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
